// File: rtl/snap_pkg.sv
// snap_pkg: constants shared by every button-input block
package snap_pkg;
    localparam int SYNC_STAGES = 2;
endpackage

// File: rtl/sync_edge_detect.sv
// sync_edge_detect: synchronises an async input and flags its rising edge
// The edge flop d samples the last synchroniser stage, so a held input yields one rise.
module sync_edge_detect #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic async_in,
    output logic rise
);
    logic [STAGES-1:0] sync;
    logic d;
    always_ff @(posedge clk) begin
        if (reset) begin
            sync <= '0;
            d <= 1'b0;
        end else begin
            sync <= {sync[STAGES-2:0], async_in};
            d <= sync[STAGES-1];
        end
    end
    assign rise = sync[STAGES-1] & ~d;
endmodule

// File: rtl/switch_snapshot_buffer.sv
// switch_snapshot_buffer: live switch hold register plus a circular history of
// captured snapshots, read back newest-first through sel.
module switch_snapshot_buffer
    import snap_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [WIDTH-1:0]             switches,
    input  logic                         retain,
    input  logic                         capture,
    input  logic                         clear,
    input  logic [$clog2(DEPTH)-1:0]     sel,
    output logic [WIDTH-1:0]             retain_output,
    output logic [WIDTH-1:0]             snap_output,
    output logic                         snap_valid,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         overflow
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0] wr_ptr, rd_idx;
    logic rise;
    sync_edge_detect #(.STAGES(SYNC_STAGES)) u_sync (
        .clk(clk),
        .reset(reset),
        .async_in(capture),
        .rise(rise)
    );
    assign rd_idx = wr_ptr - 1'b1 - sel;
    assign retain_output = q;
    always_ff @(posedge clk) begin
        if (reset) begin
            q <= '0;
            wr_ptr <= '0;
            count <= '0;
            overflow <= 1'b0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            snap_output <= '0;
            snap_valid <= 1'b0;
        end else begin
            if (!retain) q <= switches;
            // clear wins over a coincident rise; that capture is dropped
            if (clear) begin
                wr_ptr <= '0;
                count <= '0;
                overflow <= 1'b0;
                for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            end else if (rise) begin
                mem[wr_ptr] <= q;
                wr_ptr <= wr_ptr + 1'b1;
                if (count == CW'(DEPTH)) overflow <= 1'b1;
                else count <= count + 1'b1;
            end
            snap_valid <= CW'(sel) < count;
            snap_output <= (CW'(sel) < count) ? mem[rd_idx] : '0;
        end
    end
endmodule

// File: doc/switch_snapshot_buffer.md
# switch_snapshot_buffer

Parametrised successor to the switch retain register. It provides a live hold register for `WIDTH` switch inputs and adds a `DEPTH`-entry circular history of captured snapshots. A synchronised, edge-detected `capture` input stores snapshots, and `sel` reads them back, newest first. It sits between the board switch/button inputs and the display/ALU operand logic.

## Interface
Parameters:
- `WIDTH`, default 8: switch bus width.
- `DEPTH`, default 4: number of history entries. Must be a power of two, ≥2.

Ports (clock and reset first):
- `clk`, in, 1: system clock.
- `reset`, in, 1: reset, synchronous, active-high.
- `switches`, in, `WIDTH`: raw switch bus, sampled every cycle.
- `retain`, in, 1: synchronous to `clk`. 1 holds the live register; 0 makes it track `switches`.
- `capture`, in, 1: asynchronous button. Its rising edge stores one snapshot.
- `clear`, in, 1: synchronous. Empties the history.
- `sel`, in, `$clog2(DEPTH)`: history index, where 0 is the newest snapshot.
- `retain_output`, out, `WIDTH`: live register value.
- `snap_output`, out, `WIDTH`: selected snapshot, registered.
- `snap_valid`, out, 1: `sel` < `count`, registered alongside `snap_output`.
- `count`, out, `$clog2(DEPTH+1)`: number of valid entries, saturating at `DEPTH`.
- `overflow`, out, 1: sticky. Set when a capture overwrites the oldest entry.

## Operation
Live register Q:
- `retain`=0: Q ← `switches` at each edge.
- `retain`=1: Q holds its value.
- `retain_output` = Q.
- `clear` does not affect Q.

Capture path:
- `capture` passes through 2 flops (s1, s2), then an edge flop d.
- rise = s2 & ~d.
- Holding `capture` high produces exactly one rise.

On rise, without `clear` asserted:
- mem[wr_ptr] ← Q (the value before this edge).
- wr_ptr ← wr_ptr+1, wrapping mod `DEPTH`.
- If `count` < `DEPTH`: `count` increments.
- Else: `count` stays at `DEPTH`, the oldest entry is overwritten, and `overflow` ← 1.

Clear:
- `clear` forces wr_ptr, `count` and `overflow` to 0 and all mem entries to 0.
- `clear` wins over a simultaneous rise; that capture is dropped, not deferred.

Readback:
- Index = (wr_ptr − 1 − `sel`) mod `DEPTH`.
- `snap_output` ← mem[index] when `sel` < `count`, else 0.
- `snap_valid` ← (`sel` < `count`).

Reset:
- Q, s1, s2, d, wr_ptr, `count`, `overflow`, all mem entries, `snap_output` and `snap_valid` all go to 0.
- Reset mid-capture, while the edge is still in the synchroniser, loses that capture.
- A pulse still high after reset releases re-enters the synchroniser. It is captured only if `capture` is sampled high after reset while d=0.

## Timing
- `retain_output`: 1-cycle latency from `switches` when `retain`=0.
- `retain` change: takes effect at the next edge.
- Capture latency: `capture` high, first sampled by s1 at edge E0, gives s2=1 after E1. rise is high during cycle E1→E2. mem, wr_ptr and `count` update at E2. `snap_output` for `sel`=0 shows the new value after E3.
- `sel` change: `snap_output` and `snap_valid` update at the next edge (1-cycle latency).
- Clear: `count`=0 visible the cycle after the `clear` edge. `snap_valid`=0 one cycle after that.
- Capture rate: at most one capture per 2 cycles, since rise needs a low sample first. This is no constraint for buttons.
- Boundaries:
  - `count`=`DEPTH`-1 plus rise: `count`=`DEPTH`, `overflow` stays 0.
  - `count`=`DEPTH` plus rise: `count` stays, `overflow`=1.
  - wr_ptr=`DEPTH`-1 plus rise: wr_ptr=0.

## Structure
- Shared package `snap_pkg` holds the constant `SYNC_STAGES`=2, used by every button-input block.
- Pointer and count widths are derived locally from the parameters.
- Sub-module `sync_edge_detect`, parameter `STAGES`: clk, reset, async_in → rise. Contains the synchroniser flops and the edge flop.
- History is a flop array (`DEPTH`×`WIDTH`), not BRAM.

## Test plan
All scenarios use `WIDTH`=8, `DEPTH`=4.
- Reset, then `retain`=0 and `switches`=0xA5 → `retain_output`=0xA5 one edge later. `count`=0, `snap_valid`=0, `overflow`=0.
- `retain`=1 with Q=0xA5, then `switches`=0x3C → `retain_output` stays 0xA5. `retain`=0 → 0x3C next edge.
- Capture with Q=0x11 → `count`=1 at E2. With `sel`=0, `snap_output`=0x11 and `snap_valid`=1 at E3. With `sel`=1 → `snap_valid`=0, `snap_output`=0.
- Capture 0x01..0x05 in five separate pulses, `capture` held high 10 cycles each → `count`=4, `overflow`=1. Readback gives `sel` 0..3 = 0x05, 0x04, 0x03, 0x02.
- `clear` asserted on the same cycle rise is high → `count`=0 and no entry written. A following capture of 0x77 → `count`=1, `sel`=0 reads 0x77.
- `reset` asserted one cycle after `capture` rises, then released with `capture` low → `count`=0 and mem empty.
